mips_uart: RTL and testbench
============================

# mips_uart

UART front end of the MIPS board system with an on-chip echo controller. It receives 8-data-bit, even-parity serial frames on `rx` and exposes the receive shift register and the parity status. It shows the last good byte and a frame count on seven-segment displays, and retransmits every parity-clean byte on `tx`. It sits between the board pins (UART header, HEX displays) and the processor data path. `LENGTH` sets the width of the processor-side data word.

## Interface
- `LENGTH`, 32: processor data word width; received byte is zero-extended to `LENGTH` bits internally; must be ≥ 9.
- `clock`  in  1  system clock, 50 MHz (20 ns period).
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, idle high.
- `parity`  out  1  1 = last completed frame had an even-parity error; holds until next frame completes.
- `Rx_SR`  out  9  receive shift register {parity bit, data[7:0]}, live during reception, holds last frame afterwards.
- `heard_bit_out`  out  1  one-cycle strobe at each mid-bit sample of data and parity bits (9 per frame).
- `HEX0`  out  7  active-low 7-seg, bit6..0 = g..a: count of good frames mod 16, hex digit.
- `HEX2`  out  7  same encoding: low nibble of last good byte.
- `HEX3`  out  7  same encoding: high nibble of last good byte.
- `tx`  out  1  serial output, idle high.

## Operation
- Frame, both directions: start (0), data[0..7] LSB first, even parity bit (XOR of data), stop (1). 11 bits.
- Bit time is `CLKS_PER_BIT` = 434 clocks (115200 baud).
- RX path:
  - `rx` passes through a 2-flop synchronizer.
  - States IDLE → START → DATA(8) → PAR → STOP → IDLE.
  - IDLE: a synchronized 1→0 transition enters START.
  - START: sample at half bit. If the sample is high (false start), return to IDLE.
  - DATA/PAR: sample every full bit after the start-bit midpoint. Shift right into `Rx_SR`, new bit entering bit 8, so that after PAR `Rx_SR` = {par, d7..d0}. Pulse `heard_bit_out` on each sample.
  - STOP: sample at mid-bit.
    - Stop = 0 (framing error): discard the frame. No display, count or `parity` update; no echo.
    - Stop = 1: set `parity` = ^`Rx_SR`. If `parity` is 0, the byte is good.
- Good byte:
  - HEX3/HEX2 update.
  - HEX0 count increments, wrapping F→0.
  - Byte is queued for echo.
- TX path:
  - States IDLE → START → DATA(8) → PAR → STOP → IDLE, each state `CLKS_PER_BIT` clocks.
  - One-byte pending buffer. A good byte arriving while the buffer is full is dropped (overrun); the displays still update.
  - The transmitter loads from the buffer when IDLE and the buffer is full.
- Reset (any time, including mid-frame) aborts both FSMs to IDLE and clears the buffer. Output values during reset:
  - `tx`=1, `Rx_SR`=0, `parity`=0, `heard_bit_out`=0.
  - Count and byte = 0, so HEX0/HEX2/HEX3 = 7'b1000000 ("0").

## Timing
- Bit centre, RX: first data sample at 1.5 bit times (651 clocks) after the synchronized falling edge, then every 434 clocks.
- Synchronizer adds 2 clocks of input latency.
- `parity`, HEX registers and the echo-buffer load all update in the same cycle as the stop-bit sample.
- TX start bit begins within 2 clocks after the stop-bit sample of the received frame (buffer write, then TX load).
- Echoed frame ends 11×434 clocks after its start.
- Back-to-back RX frames are supported: a new start bit is accepted immediately after the stop-bit sample.
- All outputs are registered.

## Structure
- Package `mips_uart_pkg`:
  - `CLKS_PER_BIT` = 434 and `HALF_BIT` = 217.
  - RX/TX state enum.
  - 7-seg encoding function (nibble→segments, 0–F).
- Sub-modules:
  - `uart_rx`: synchronizer, RX FSM, `Rx_SR`, parity check, `heard_bit_out`.
  - `uart_tx`: TX FSM, parity generation.
- Top: echo buffer, frame counter, display registers.

## Test plan
- Reset low for 5 clocks, idle `rx`=1 → `tx`=1, `Rx_SR`=0, `parity`=0, all HEX=7'b1000000.
- Send 0x5A, parity 0 → 9 `heard_bit_out` strobes; `Rx_SR`=9'h05A, `parity`=0; HEX3="5" (7'b0010010), HEX2="A" (7'b0001000), HEX0="1" (7'b1111001); `tx` echoes 0 0101 1010(LSB first) 0 1.
- Send 0x5A with parity 1 → `parity`=1, `Rx_SR`=9'h15A; HEX unchanged; no `tx` activity.
- Send 0x33 with stop bit 0 → no HEX/`parity` change, no echo.
- 200-clock low glitch on `rx` → false start; no strobes, state returns to IDLE.
- Three back-to-back good frames 0x01, 0x02, 0x03 → the byte arriving while the buffer is still full is dropped from the echo (only 0x01 and 0x03 echo, in that order); HEX0="3", HEX2="3"; then assert reset mid-echo → `tx`=1 immediately.

Source files
------------

// File: rtl/mips_uart_pkg.sv
// Shared constants, FSM state encoding and seven-segment decode for the MIPS board UART.
package mips_uart_pkg;

  localparam int unsigned CLKS_PER_BIT = 434;
  localparam int unsigned HALF_BIT     = 217;
  localparam int unsigned CNT_W        = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  // Active-low segments, bit6..0 = g..a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_uart_rx.sv
// UART receiver: input synchronizer, frame FSM, shift register and even-parity check.
module uart_rx
  import mips_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [8:0] rx_sr,
  output logic       parity,
  output logic       heard,
  output logic       good_c
);

  logic             rx_meta, rx_sync, rx_prev;
  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [8:0]       sr_nxt;
  logic             parity_nxt, heard_nxt;
  logic             bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    sr_nxt      = rx_sr;
    parity_nxt  = parity;
    heard_nxt   = 1'b0;
    good_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = ST_START;
      end
      ST_START: begin
        // Half-bit check filters glitches shorter than the start-bit centre.
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA, ST_PAR: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          sr_nxt    = {rx_sync, rx_sr[8:1]};
          heard_nxt = 1'b1;
          if (state == ST_PAR)         state_nxt   = ST_STOP;
          else if (bit_idx == 3'd7)    state_nxt   = ST_PAR;
          else                         bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
          if (rx_sync) begin
            parity_nxt = ^rx_sr;
            good_c     = ~(^rx_sr);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_sr   <= '0;
      parity  <= 1'b0;
      heard   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      rx_sr   <= sr_nxt;
      parity  <= parity_nxt;
      heard   <= heard_nxt;
    end
  end

endmodule

// File: rtl/mips_uart_tx.sv
// UART transmitter: 8 data bits LSB first, even parity, one stop bit.
module uart_tx
  import mips_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle_c,
  output logic       done_c
);

  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       sh, sh_nxt;
  logic             par_q, par_nxt, tx_nxt;
  logic             bit_end;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign idle_c  = (state == ST_IDLE);

  // tx_nxt always carries the line level of the state being entered.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    sh_nxt      = sh;
    par_nxt     = par_q;
    tx_nxt      = tx;
    done_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = 1'b1;
        if (load) begin
          state_nxt = ST_START;
          sh_nxt    = data;
          par_nxt   = ^data;
          tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          tx_nxt      = sh[0];
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = par_q;
            state_nxt = ST_PAR;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            sh_nxt      = {1'b0, sh[7:1]};
            tx_nxt      = sh[1];
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      sh      <= sh_nxt;
      par_q   <= par_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: rtl/mips_uart.sv
// MIPS board UART front end: receiver, echo buffer, frame counter and HEX displays.
module mips_uart
  import mips_uart_pkg::*;
#(
  parameter int unsigned LENGTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       parity,
  output logic [8:0] Rx_SR,
  output logic       heard_bit_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       tx
);

  logic              good_c, tx_idle_c, tx_done_c, load_c, accept_c;
  logic              buf_full, buf_sent;
  logic [7:0]        buf_data;
  logic [3:0]        count;
  logic [LENGTH-1:0] rx_word;
  logic              unused_word_hi;

  uart_rx u_rx (
    .clk    (clock),
    .rst_n  (reset),
    .rx     (rx),
    .rx_sr  (Rx_SR),
    .parity (parity),
    .heard  (heard_bit_out),
    .good_c (good_c)
  );

  uart_tx u_tx (
    .clk    (clock),
    .rst_n  (reset),
    .load   (load_c),
    .data   (buf_data),
    .tx     (tx),
    .idle_c (tx_idle_c),
    .done_c (tx_done_c)
  );

  assign rx_word        = LENGTH'(Rx_SR[7:0]);
  assign unused_word_hi = ^rx_word[LENGTH-1:8];

  // The buffer stays occupied until its byte has fully left the line; a byte
  // arriving in the very cycle the transmitter finishes is still accepted.
  assign load_c   = buf_full & ~buf_sent & tx_idle_c;
  assign accept_c = good_c & (~buf_full | tx_done_c);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_sent <= 1'b0;
      buf_data <= '0;
      count    <= '0;
      HEX0     <= seg7(4'h0);
      HEX2     <= seg7(4'h0);
      HEX3     <= seg7(4'h0);
    end else begin
      if (good_c) begin
        count <= count + 4'd1;
        HEX0  <= seg7(count + 4'd1);
        HEX2  <= seg7(rx_word[3:0]);
        HEX3  <= seg7(rx_word[7:4]);
      end
      if (tx_done_c) begin
        buf_full <= 1'b0;
        buf_sent <= 1'b0;
      end
      if (load_c) buf_sent <= 1'b1;
      if (accept_c) begin
        buf_full <= 1'b1;
        buf_sent <= 1'b0;
        buf_data <= rx_word[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mips_uart.sv
// Bench for mips_uart: drives serial frames, checks status/displays and scoreboards the echo.
module tb_mips_uart;

  localparam int BIT  = 434;
  localparam int HALF = 217;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_A = 7'b0001000;

  logic       clock, reset, rx;
  logic       parity, heard_bit_out, tx;
  logic [8:0] Rx_SR;
  logic [6:0] HEX0, HEX2, HEX3;

  int n_pass, n_checks;
  int strobes, echo_cnt, epoch;
  int base_strobes, base_echo;
  logic [7:0] exp_q[$];

  mips_uart #(.LENGTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .parity        (parity),
    .Rx_SR         (Rx_SR),
    .heard_bit_out (heard_bit_out),
    .HEX0          (HEX0),
    .HEX2          (HEX2),
    .HEX3          (HEX3),
    .tx            (tx)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_bit);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic wait_echoes(input int n);
    for (int i = 0; i < 12000 && echo_cnt < n; i++) @(posedge clock);
    #1;
    check("echo_count", 32'(echo_cnt), 32'(n));
  endtask

  task automatic check_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h0);
    check({tag, "_hex3"}, 32'(HEX3), 32'(h3));
    check({tag, "_hex2"}, 32'(HEX2), 32'(h2));
    check({tag, "_hex0"}, 32'(HEX0), 32'(h0));
  endtask

  always @(negedge clock) if (heard_bit_out === 1'b1) strobes++;

  // Echo monitor: samples tx at bit centres and pops the expected byte.
  logic [7:0]  mon_b;
  logic        mon_st, mon_p, mon_s;
  int          mon_ep;
  logic [31:0] mon_exp;
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && tx === 1'b0) begin
        mon_ep = epoch;
        repeat (HALF) @(negedge clock);
        mon_st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clock);
          mon_b[i] = tx;
        end
        repeat (BIT) @(negedge clock);
        mon_p = tx;
        repeat (BIT) @(negedge clock);
        mon_s = tx;
        if (mon_ep == epoch) begin
          echo_cnt++;
          mon_exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
          check("echo_byte",  32'(mon_b),  mon_exp);
          check("echo_start", 32'(mon_st), 32'd0);
          check("echo_par",   32'(mon_p),  32'(^mon_exp[7:0]));
          check("echo_stop",  32'(mon_s),  32'd1);
        end
      end
    end
  end

  initial begin
    n_pass = 0; n_checks = 0; strobes = 0; echo_cnt = 0; epoch = 0;
    rx = 1'b1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_sr", 32'(Rx_SR), 32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    check("rst_heard", 32'(heard_bit_out), 32'd0);
    check_hex("rst", SEG_0, SEG_0, SEG_0);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    // Good frame 0x5A
    base_strobes = strobes;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("good_strobes", 32'(strobes - base_strobes), 32'd9);
    check("good_rx_sr", 32'(Rx_SR), 32'h05A);
    check("good_parity", 32'(parity), 32'd0);
    check_hex("good", SEG_5, SEG_A, SEG_1);
    wait_echoes(1);
    check("good_q_empty", 32'(exp_q.size()), 32'd0);

    // Parity error: status updates, displays and echo do not
    base_strobes = strobes;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    check("perr_strobes", 32'(strobes - base_strobes), 32'd9);
    check("perr_rx_sr", 32'(Rx_SR), 32'h15A);
    check("perr_parity", 32'(parity), 32'd1);
    check_hex("perr", SEG_5, SEG_A, SEG_1);

    // Framing error: frame discarded entirely
    send_frame(8'h33, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("ferr_parity", 32'(parity), 32'd1);
    check("ferr_rx_sr", 32'(Rx_SR), 32'h033);
    check_hex("ferr", SEG_5, SEG_A, SEG_1);
    repeat (5000) @(posedge clock);
    #1;
    check("no_echo", 32'(echo_cnt), 32'd1);

    // Reset again so the back-to-back sequence counts from zero
    reset = 1'b0;
    epoch++;
    repeat (3) @(posedge clock);
    #1;
    check("rst2_rx_sr", 32'(Rx_SR), 32'd0);
    check("rst2_parity", 32'(parity), 32'd0);
    check_hex("rst2", SEG_0, SEG_0, SEG_0);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    // 200-clock glitch is a false start
    base_strobes = strobes;
    rx = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (1000) @(posedge clock);
    #1;
    check("glitch_strobes", 32'(strobes - base_strobes), 32'd0);
    check("glitch_rx_sr", 32'(Rx_SR), 32'd0);

    // Back-to-back: 0x02 lands while 0x01 is still in the buffer and is dropped
    base_strobes = strobes;
    base_echo = echo_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    check("b2b_strobes", 32'(strobes - base_strobes), 32'd27);
    check("b2b_rx_sr", 32'(Rx_SR), 32'h003);
    check("b2b_parity", 32'(parity), 32'd0);
    check_hex("b2b", SEG_0, SEG_3, SEG_3);
    check("b2b_echoes", 32'(echo_cnt - base_echo), 32'd1);
    check("b2b_echo_active", 32'(tx), 32'd0);

    // Reset mid-echo forces the line idle at once
    reset = 1'b0;
    epoch++;
    #1;
    check("midecho_tx", 32'(tx), 32'd1);
    check("pending_len", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) check("pending_byte", 32'(exp_q[0]), 32'h03);
    repeat (5) @(posedge clock);
    #1;
    check("rst3_tx", 32'(tx), 32'd1);
    check_hex("rst3", SEG_0, SEG_0, SEG_0);
    reset = 1'b1;
    repeat (500) @(posedge clock);
    #1;
    check("post_tx_idle", 32'(tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
